// File: rtl/apb_master_pkg.sv
// Shared types for the APB master bridge: FSM states and the captured
// request / response records.
package apb_master_pkg;

  // Width of the captured address field. The bridge's ADDR_WIDTH must match it.
  localparam int unsigned AddrWidth = 24;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  typedef struct packed {
    logic                 write;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           strb;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } rsp_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready host port to APB4 master bridge. One transfer in flight at a
// time; stalled ACCESS phases are terminated by a saturating timeout counter.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = AddrWidth,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [2:0]  PPROT_VAL      = 3'b000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [3:0]            req_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  apb_psel,
  output logic                  apb_penable,
  output logic [ADDR_WIDTH-1:0] apb_paddr,
  output logic                  apb_pwrite,
  output logic [31:0]           apb_pwdata,
  output logic [3:0]            apb_pstrb,
  output logic [2:0]            apb_pprot,
  input  logic [31:0]           apb_prdata,
  input  logic                  apb_pready,
  input  logic                  apb_pslverr,
  output logic                  busy
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  rsp_t            rsp_q, rsp_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            psel_q, penable_q, rsp_valid_q, req_ready_q;

  // Next-state, request capture, response capture and timeout counting.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          req_d.write = req_write;
          // Word-align; low address bits are deliberately discarded.
          req_d.addr  = AddrWidth'(req_addr & ~ADDR_WIDTH'(3));
          req_d.wdata = req_wdata;
          req_d.strb  = req_write ? req_strb : 4'b0000;
          cnt_d       = '0;
          state_d     = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (apb_pready) begin
          rsp_d.rdata   = req_q.write ? 32'h0 : apb_prdata;
          rsp_d.err     = apb_pslverr;
          rsp_d.timeout = 1'b0;
          state_d       = StResp;
        end else begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CntW'(1);
          end
          if ((TIMEOUT_CYCLES != 0) && (cnt_d == CntW'(TIMEOUT_CYCLES))) begin
            rsp_d.rdata   = 32'h0;
            rsp_d.err     = 1'b1;
            rsp_d.timeout = 1'b1;
            state_d       = StResp;
          end
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, captured fields and registered handshake/APB control outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      req_q       <= '0;
      rsp_q       <= '0;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_q       <= rsp_d;
      cnt_q       <= cnt_d;
      psel_q      <= (state_d == StSetup) || (state_d == StAccess);
      penable_q   <= (state_d == StAccess);
      rsp_valid_q <= (state_d == StResp);
      req_ready_q <= (state_d == StIdle);
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_q.rdata;
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign apb_psel    = psel_q;
  assign apb_penable = penable_q;
  assign apb_paddr   = ADDR_WIDTH'(req_q.addr);
  assign apb_pwrite  = req_q.write;
  assign apb_pwdata  = req_q.wdata;
  assign apb_pstrb   = req_q.strb;
  assign apb_pprot   = PPROT_VAL;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge with a small behavioural
// APB register slave (write and prdata capture in SETUP, optional stall/error).
module tb_apb_master_bridge;

  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_strb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          apb_psel;
  logic          apb_penable;
  logic [AW-1:0] apb_paddr;
  logic          apb_pwrite;
  logic [31:0]   apb_pwdata;
  logic [3:0]    apb_pstrb;
  logic [2:0]    apb_pprot;
  logic [31:0]   apb_prdata;
  logic          apb_pready;
  logic          apb_pslverr;
  logic          busy;

  logic          stall = 1'b0;
  logic          err_mode = 1'b0;
  logic [31:0]   regs [16];

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(16),
    .PPROT_VAL     (3'b000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_strb   (req_strb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .apb_psel   (apb_psel),
    .apb_penable(apb_penable),
    .apb_paddr  (apb_paddr),
    .apb_pwrite (apb_pwrite),
    .apb_pwdata (apb_pwdata),
    .apb_pstrb  (apb_pstrb),
    .apb_pprot  (apb_pprot),
    .apb_prdata (apb_prdata),
    .apb_pready (apb_pready),
    .apb_pslverr(apb_pslverr),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Slave: pready/pslverr driven from bench controls.
  assign apb_pready  = ~stall;
  assign apb_pslverr = err_mode;

  // Slave register file: writes and prdata capture happen in SETUP.
  always @(posedge clk) begin
    if (apb_psel && !apb_penable) begin
      if (apb_pwrite) begin
        for (int b = 0; b < 4; b++) begin
          if (apb_pstrb[b]) regs[apb_paddr[5:2]][8*b +: 8] <= apb_pwdata[8*b +: 8];
        end
      end
      apb_prdata <= regs[apb_paddr[5:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the SETUP cycle.
  task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                      input logic [3:0] st);
    int n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_strb  = st;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Latency counted in cycles from the request handshake cycle.
  task automatic wait_rsp(input int bound, output int lat, output logic last_psel);
    lat = 1;
    last_psel = apb_psel;
    while (!rsp_valid && lat < bound) begin
      last_psel = apb_psel;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_valid_wait", 32'd0, 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  int   lat;
  logic lp;
  logic stale;

  initial begin
    // Reset state.
    #2 resetn = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_psel", 32'(apb_psel), 32'd0);
    check("rst_penable", 32'(apb_penable), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pprot", 32'(apb_pprot), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1 check("rst_release_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Full-word write to 0x4.
    send(1'b1, 24'h000004, 32'hDEADBEEF, 4'hF);
    check("wr_setup_psel", 32'(apb_psel), 32'd1);
    check("wr_setup_penable", 32'(apb_penable), 32'd0);
    check("wr_setup_pstrb", 32'(apb_pstrb), 32'hF);
    check("wr_setup_paddr", 32'(apb_paddr), 32'h4);
    check("wr_setup_pwdata", apb_pwdata, 32'hDEADBEEF);
    check("wr_setup_busy", 32'(busy), 32'd1);
    check("wr_setup_req_ready", 32'(req_ready), 32'd0);
    wait_rsp(40, lat, lp);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_err", 32'(rsp_err), 32'd0);
    check("wr_rdata", rsp_rdata, 32'h0);
    consume();

    // Read back.
    send(1'b0, 24'h000004, 32'h0, 4'hF);
    check("rd_setup_pstrb", 32'(apb_pstrb), 32'h0);
    check("rd_setup_pwrite", 32'(apb_pwrite), 32'd0);
    wait_rsp(40, lat, lp);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
    check("rd_err", 32'(rsp_err), 32'd0);
    consume();

    // Partial strobe.
    send(1'b1, 24'h000004, 32'hFFFFFFFF, 4'hF);
    wait_rsp(40, lat, lp);
    consume();
    send(1'b1, 24'h000004, 32'h00000000, 4'h3);
    check("part_setup_pstrb", 32'(apb_pstrb), 32'h3);
    wait_rsp(40, lat, lp);
    consume();
    send(1'b0, 24'h000004, 32'h0, 4'hF);
    check("part_rd_pstrb", 32'(apb_pstrb), 32'h0);
    wait_rsp(40, lat, lp);
    check("part_rdata", rsp_rdata, 32'hFFFF0000);
    consume();

    // Address alignment.
    send(1'b1, 24'h00000B, 32'h12345678, 4'hF);
    check("align_paddr", 32'(apb_paddr), 32'h8);
    wait_rsp(40, lat, lp);
    consume();
    send(1'b0, 24'h000008, 32'h0, 4'h0);
    wait_rsp(40, lat, lp);
    check("align_rdata", rsp_rdata, 32'h12345678);
    consume();

    // Timeout: 16 stalled ACCESS cycles.
    stall = 1'b1;
    send(1'b0, 24'h000008, 32'h0, 4'h0);
    wait_rsp(60, lat, lp);
    check("to_latency", 32'(lat), 32'd18);
    check("to_err", 32'(rsp_err), 32'd1);
    check("to_timeout", 32'(rsp_timeout), 32'd1);
    check("to_rdata", rsp_rdata, 32'h0);
    check("to_psel_before", 32'(lp), 32'd1);
    check("to_psel_after", 32'(apb_psel), 32'd0);
    consume();
    stall = 1'b0;

    // Slave error with response back-pressure.
    err_mode = 1'b1;
    send(1'b0, 24'h000000, 32'h0, 4'h0);
    wait_rsp(40, lat, lp);
    err_mode = 1'b0;
    check("serr_err", 32'(rsp_err), 32'd1);
    check("serr_timeout", 32'(rsp_timeout), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("serr_hold_valid", 32'(rsp_valid), 32'd1);
      check("serr_hold_req_ready", 32'(req_ready), 32'd0);
      check("serr_hold_err", 32'(rsp_err), 32'd1);
    end
    consume();
    check("serr_done_valid", 32'(rsp_valid), 32'd0);

    // Reset during ACCESS.
    stall = 1'b1;
    send(1'b0, 24'h000008, 32'h0, 4'h0);
    @(negedge clk);
    check("mid_access_penable", 32'(apb_penable), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("mid_rst_psel", 32'(apb_psel), 32'd0);
    check("mid_rst_penable", 32'(apb_penable), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    stall = 1'b0;
    @(posedge clk);
    #1 check("mid_release_ready", 32'(req_ready), 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid || apb_psel) stale = 1'b1;
    end
    check("mid_no_stale", 32'(stale), 32'd0);

    // Normal traffic after the reset.
    send(1'b0, 24'h000008, 32'h0, 4'h0);
    wait_rsp(40, lat, lp);
    check("post_rst_latency", 32'(lat), 32'd3);
    check("post_rst_rdata", rsp_rdata, 32'h12345678);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
